// File: rtl/dequant_pkg.sv
// Shared definitions for the dequantization scheduler: controller states,
// default datapath widths and the fixed-point shift applied to the product.
package dequant_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int SCALE_W_DEF = 16;
   localparam int DEQ_SHIFT   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } DeqState;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. It grants at most one requesting lane per cycle, and
// only while enabled. The search starts at the lane after the most recently
// granted one. The pointer comes out of reset at lane 0.
module rr_arbiter #(
   parameter int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [N_REQ-1:0] req_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o
);

   localparam int LW = IDX_W + 1;

   logic [IDX_W-1:0] ptrQ;
   logic [IDX_W-1:0] ptrD;
   logic [LW-1:0]    lane;
   logic             found;

   // Scan the lanes starting at the pointer, wrapping around, and grant the first requester
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      lane    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         lane = {1'b0, ptrQ} + LW'(i);
         if (lane >= LW'(N_REQ)) begin
            lane = lane - LW'(N_REQ);
         end
         if (en_i && !found && req_i[lane[IDX_W-1:0]]) begin
            found                    = 1'b1;
            grant_o[lane[IDX_W-1:0]] = 1'b1;
            idx_o                    = lane[IDX_W-1:0];
         end
      end
   end

   // After a grant, move the search start to the lane just past the winner
   always_comb begin
      ptrD = ptrQ;
      if (found) begin
         ptrD = (idx_o == IDX_W'(N_REQ - 1)) ? '0 : idx_o + IDX_W'(1);
      end
   end

   // Pointer register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptrQ <= '0;
      end else begin
         ptrQ <= ptrD;
      end
   end

endmodule

// File: rtl/dequant_scheduler.sv
// Dequantization stage controller. It shares one two-stage unsigned
// multiplier among N_REQ ReLU lanes through round-robin arbitration. The
// result is ((relu * X_s) * w_s) >> 16, truncated to DATA_W. The controller
// counts the layer's results, drains the pipeline and pulses o_done.
// Optional build macro: DEQUANT_SATURATE_EN. When it is defined, a result
// that overflows DATA_W after the shift clamps to all ones instead of
// wrapping.
module dequant_scheduler
   import dequant_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int SCALE_W = SCALE_W_DEF,
   parameter int CNT_W   = 16,
   localparam int IDX_W  = $clog2(N_REQ)
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_cfg_load,
   input  logic [31:0]             i_X_s,
   input  logic [31:0]             i_w_s,
   input  logic [CNT_W-1:0]        i_cfg_count,
   input  logic                    i_start,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ*DATA_W-1:0] i_req_data,
   output logic [N_REQ-1:0]        o_req_ready,
   output logic                    o_valid,
   output logic [DATA_W-1:0]       o_data,
   output logic [IDX_W-1:0]        o_src_id,
   input  logic                    i_ready,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_cfg_err
);

   localparam int P1_W = DATA_W + SCALE_W;
   localparam int P2_W = DATA_W + 2 * SCALE_W;

   DeqState            stateQ;
   DeqState            stateD;
   logic [SCALE_W-1:0] xsQ;
   logic [SCALE_W-1:0] wsQ;
   logic [CNT_W-1:0]   cntQ;
   logic [CNT_W-1:0]   accQ;
   logic [CNT_W-1:0]   accNext;
   logic               cfgValidQ;
   logic               busyQ;
   logic               cfgErrQ;
   logic               cfgErrD;
   logic               loadOk;
   logic               startOk;

   logic               s1ValidQ;
   logic [P1_W-1:0]    s1ProdQ;
   logic [IDX_W-1:0]   s1SrcQ;
   logic               s2ValidQ;
   logic [DATA_W-1:0]  s2DataQ;
   logic [IDX_W-1:0]   s2SrcQ;

   logic               advance;
   logic               grantEn;
   logic               transfer;
   logic               drainEmpty;
   logic [N_REQ-1:0]   grant;
   logic [IDX_W-1:0]   grantIdx;
   logic [DATA_W-1:0]  selData;
   logic [P1_W-1:0]    p1;
   logic [P2_W-1:0]    p2;
   logic [DATA_W-1:0]  deqResult;
   logic               unusedBits;

   // The pipeline moves forward whenever the output slot is free or is being consumed.
   assign advance    = !s2ValidQ || i_ready;
   assign grantEn    = (stateQ == RUN) && advance && (accQ != cntQ);
   assign transfer   = |grant;
   assign accNext    = accQ + CNT_W'(transfer);
   assign drainEmpty = !s1ValidQ && !s2ValidQ;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) uArbiter (
      .clk_i   (i_clk),
      .reset_i (i_reset),
      .req_i   (i_req_valid),
      .en_i    (grantEn),
      .grant_o (grant),
      .idx_o   (grantIdx)
   );

   assign selData   = i_req_data[int'(grantIdx) * DATA_W +: DATA_W];
   assign p1        = P1_W'(selData) * P1_W'(xsQ);
   assign p2        = P2_W'(s1ProdQ) * P2_W'(wsQ);

`ifdef DEQUANT_SATURATE_EN
   assign deqResult = (|p2[P2_W-1:DATA_W+DEQ_SHIFT]) ? '1 : p2[DATA_W+DEQ_SHIFT-1:DEQ_SHIFT];
`else
   assign deqResult = p2[DATA_W+DEQ_SHIFT-1:DEQ_SHIFT];
`endif

   assign unusedBits = ^{i_X_s[31:SCALE_W], i_w_s[31:SCALE_W], p2};

   // Controller: config latching, layer start, end-of-count and drain handling, ignored-command detection
   always_comb begin
      stateD  = stateQ;
      loadOk  = 1'b0;
      startOk = 1'b0;
      cfgErrD = 1'b0;
      case (stateQ)
         IDLE: begin
            loadOk = i_cfg_load;
            if (i_start) begin
               if (cfgValidQ || i_cfg_load) begin
                  startOk = 1'b1;
                  stateD  = RUN;
               end else begin
                  cfgErrD = 1'b1;
               end
            end
         end
         RUN: begin
            cfgErrD = i_cfg_load || i_start;
            if (accNext == cntQ) begin
               stateD = DRAIN;
            end
         end
         DRAIN: begin
            cfgErrD = i_cfg_load || i_start;
            if (drainEmpty) begin
               stateD = IDLE;
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // Control registers: state, latched configuration, result counter, status pulses
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         stateQ    <= IDLE;
         cfgValidQ <= 1'b0;
         xsQ       <= '0;
         wsQ       <= '0;
         cntQ      <= '0;
         accQ      <= '0;
         busyQ     <= 1'b0;
         cfgErrQ   <= 1'b0;
      end else begin
         stateQ  <= stateD;
         busyQ   <= (stateD != IDLE);
         cfgErrQ <= cfgErrD;
         if (loadOk) begin
            xsQ       <= i_X_s[SCALE_W-1:0];
            wsQ       <= i_w_s[SCALE_W-1:0];
            cntQ      <= i_cfg_count;
            cfgValidQ <= 1'b1;
         end
         if (startOk) begin
            accQ <= '0;
         end else if (transfer) begin
            accQ <= accNext;
         end
      end
   end

   // Two-stage multiply pipeline; both stages freeze together under backpressure
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s1ValidQ <= 1'b0;
         s1ProdQ  <= '0;
         s1SrcQ   <= '0;
         s2ValidQ <= 1'b0;
         s2DataQ  <= '0;
         s2SrcQ   <= '0;
      end else if (advance) begin
         s1ValidQ <= transfer;
         if (transfer) begin
            s1ProdQ <= p1;
            s1SrcQ  <= grantIdx;
         end
         s2ValidQ <= s1ValidQ;
         if (s1ValidQ) begin
            s2DataQ <= deqResult;
            s2SrcQ  <= s1SrcQ;
         end
      end
   end

   assign o_req_ready = grant;
   assign o_valid     = s2ValidQ;
   assign o_data      = s2DataQ;
   assign o_src_id    = s2SrcQ;
   assign o_busy      = busyQ;
   assign o_done      = (stateQ == DRAIN) && drainEmpty;
   assign o_cfg_err   = cfgErrQ;

endmodule

// File: tb/tb_dequant_scheduler.sv
// Testbench for dequant_scheduler. The stimulus process drives random and
// directed layers and keeps a behavioural model of the controller.
// Predicted results go into a scoreboard queue. A separate monitor compares
// them against every presented output.
module tb_dequant_scheduler;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
   localparam int IDX_W  = 2;

   localparam int MODE_ALL    = 0;
   localparam int MODE_SINGLE = 1;
   localparam int MODE_STALL  = 2;
   localparam int MODE_RANDOM = 3;

   logic                    i_clk = 1'b0;
   logic                    i_reset;
   logic                    i_cfg_load;
   logic [31:0]             i_X_s;
   logic [31:0]             i_w_s;
   logic [CNT_W-1:0]        i_cfg_count;
   logic                    i_start;
   logic [N_REQ-1:0]        i_req_valid;
   logic [N_REQ*DATA_W-1:0] i_req_data;
   logic [N_REQ-1:0]        o_req_ready;
   logic                    o_valid;
   logic [DATA_W-1:0]       o_data;
   logic [IDX_W-1:0]        o_src_id;
   logic                    i_ready;
   logic                    o_busy;
   logic                    o_done;
   logic                    o_cfg_err;

   always #5 i_clk = ~i_clk;

   dequant_scheduler #(
      .N_REQ   (N_REQ),
      .DATA_W  (DATA_W),
      .SCALE_W (16),
      .CNT_W   (CNT_W)
   ) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_cfg_load  (i_cfg_load),
      .i_X_s       (i_X_s),
      .i_w_s       (i_w_s),
      .i_cfg_count (i_cfg_count),
      .i_start     (i_start),
      .i_req_valid (i_req_valid),
      .i_req_data  (i_req_data),
      .o_req_ready (o_req_ready),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_src_id    (o_src_id),
      .i_ready     (i_ready),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_cfg_err   (o_cfg_err)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      int                src;
   } ExpItem;

   ExpItem expQ[$];
   int     errCount   = 0;
   int     checkCount = 0;

   // Behavioural model of the controller
   bit          active         = 1'b0;
   bit          cfgLoaded      = 1'b0;
   bit          drainSeen      = 1'b0;
   bit          slot1          = 1'b0;
   bit          slot2          = 1'b0;
   bit          errExp         = 1'b0;
   bit          checkResetNext = 1'b0;
   logic [15:0] cfgX           = '0;
   logic [15:0] cfgW           = '0;
   int          cfgCnt         = 0;
   int          accepted       = 0;
   int          rrPtr          = 0;
   int          predLane       = -1;

   // Reference arithmetic: exact 64-bit product, then shift and truncate (or clamp)
   function automatic logic [DATA_W-1:0] dequantRef(input logic [31:0] relu, input logic [15:0] x,
                                                    input logic [15:0] w);
      logic [63:0] full;
      full = 64'(relu) * 64'(x) * 64'(w);
`ifdef DEQUANT_SATURATE_EN
      if (full[63:48] != 16'd0) begin
         return '1;
      end
`endif
      return full[47:16];
   endfunction

   task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Compare the control outputs with the model mid-cycle and predict this cycle's grant
   task automatic checkOutput();
      logic [N_REQ-1:0] expReady;
      bit               adv;
      predLane = -1;
      if (i_reset) return;
      if (checkResetNext) begin
         checkVal("reset_o_valid", 64'(o_valid), 64'd0);
         checkVal("reset_o_data", 64'(o_data), 64'd0);
         checkVal("reset_o_src_id", 64'(o_src_id), 64'd0);
         checkResetNext = 1'b0;
      end
      adv = !slot2 || i_ready;
      if (active && accepted < cfgCnt && adv) begin
         for (int k = 0; k < N_REQ; k++) begin
            int lane;
            lane = (rrPtr + k) % N_REQ;
            if (predLane < 0 && i_req_valid[lane]) predLane = lane;
         end
      end
      expReady = '0;
      if (predLane >= 0) expReady[predLane] = 1'b1;
      checkVal("req_ready", 64'(o_req_ready), 64'(expReady));
      checkVal("busy", 64'(o_busy), 64'(active));
      checkVal("done", 64'(o_done), 64'(active && drainSeen && !slot1 && !slot2));
      checkVal("cfg_err", 64'(o_cfg_err), 64'(errExp));
      if (predLane >= 0) begin
         expQ.push_back('{data: dequantRef(i_req_data[predLane*DATA_W +: DATA_W], cfgX, cfgW),
                          src: predLane});
      end
   endtask

   // Advance the model on the clock edge using the inputs the DUT is sampling
   task automatic updateModel();
      bit wasActive;
      bit doneNow;
      if (i_reset) begin
         active = 0; cfgLoaded = 0; drainSeen = 0; slot1 = 0; slot2 = 0;
         errExp = 0; rrPtr = 0; accepted = 0; checkResetNext = 1;
         expQ.delete();
         return;
      end
      wasActive = active;
      errExp    = wasActive ? (i_cfg_load || i_start) : (i_start && !cfgLoaded && !i_cfg_load);
      doneNow   = active && drainSeen && !slot1 && !slot2;
      if (!slot2 || i_ready) begin
         slot2 = slot1;
         slot1 = (predLane >= 0);
      end
      if (predLane >= 0) begin
         accepted++;
         rrPtr = (predLane + 1) % N_REQ;
      end
      if (doneNow) begin
         active    = 0;
         drainSeen = 0;
      end else if (active && accepted == cfgCnt) begin
         drainSeen = 1;
      end
      if (!wasActive) begin
         if (i_cfg_load) begin
            cfgX      = i_X_s[15:0];
            cfgW      = i_w_s[15:0];
            cfgCnt    = int'(i_cfg_count);
            cfgLoaded = 1;
         end
         if (i_start && cfgLoaded) begin
            active    = 1;
            accepted  = 0;
            drainSeen = 0;
         end
      end
   endtask

   // Drive one cycle of inputs, check mid-cycle, then step the model at the edge
   task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic rdy, input logic load,
                                input logic start, input logic [15:0] xs, input logic [15:0] ws,
                                input int cnt, input bit useFix, input logic [DATA_W-1:0] fixData);
      i_req_valid = valid;
      for (int k = 0; k < N_REQ; k++) begin
         i_req_data[k*DATA_W +: DATA_W] = useFix ? fixData : DATA_W'($urandom);
      end
      i_ready     = rdy;
      i_cfg_load  = load;
      i_start     = start;
      i_X_s       = {16'($urandom), xs};
      i_w_s       = {16'($urandom), ws};
      i_cfg_count = CNT_W'(cnt);
      @(negedge i_clk);
      checkOutput();
      @(posedge i_clk);
      updateModel();
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int c = 0; c < n; c++) applyStimulus('0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 0, 1'b0, '0);
   endtask

   task automatic doReset(input int n);
      i_reset = 1'b1;
      idleCycles(n);
      i_reset = 1'b0;
   endtask

   // Configure, start and run one layer until the model reports completion
   task automatic runLayer(input int cnt, input logic [15:0] xs, input logic [15:0] ws, input int mode,
                           input int stallAt, input bit sameCycle, input logic [DATA_W-1:0] fixData);
      int               cyc;
      logic [N_REQ-1:0] valid;
      logic             rdy;
      logic             load;
      logic             start;
      if (sameCycle) begin
         applyStimulus('0, 1'b1, 1'b1, 1'b1, xs, ws, cnt, 1'b0, '0);
      end else begin
         applyStimulus('0, 1'b1, 1'b1, 1'b0, xs, ws, cnt, 1'b0, '0);
         applyStimulus('0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 0, 1'b0, '0);
      end
      cyc = 0;
      while (active && cyc < 400) begin
         valid = '1; rdy = 1'b1; load = 1'b0; start = 1'b0;
         case (mode)
            MODE_SINGLE: valid = 4'b0001;
            MODE_STALL: begin
               if (cyc >= stallAt && cyc < stallAt + 3) rdy = 1'b0;
               if (cyc == 1) load = 1'b1;
            end
            MODE_RANDOM: begin
               valid = N_REQ'($urandom);
               rdy   = ($urandom_range(0, 3) != 0);
               load  = ($urandom_range(0, 19) == 0);
               start = ($urandom_range(0, 19) == 0);
            end
            default: ;
         endcase
         applyStimulus(valid, rdy, load, start, ~xs, ~ws, cnt + 3, mode == MODE_SINGLE, fixData);
         cyc++;
      end
      if (active) begin
         errCount++;
         checkCount++;
         $display("[TB] FAIL layer_timeout: still busy after %0d cycles, expected done", cyc);
         doReset(1);
      end
      checkVal("scoreboard_drained", 64'(expQ.size()), 64'd0);
   endtask

   // Monitor: every presented result must match the oldest outstanding prediction
   always @(negedge i_clk) begin
      if (!i_reset && o_valid) begin
         if (expQ.size() == 0) begin
            errCount++;
            checkCount++;
            $display("[TB] FAIL unexpected_output: got data 0x%0h src %0d, expected no output", o_data, o_src_id);
         end else begin
            checkVal("out_data", 64'(o_data), 64'(expQ[0].data));
            checkVal("out_src_id", 64'(o_src_id), 64'(expQ[0].src));
            if (i_ready) void'(expQ.pop_front());
         end
      end
   end

   initial begin
      i_reset = 1'b1; i_cfg_load = 1'b0; i_start = 1'b0; i_ready = 1'b1;
      i_X_s = '0; i_w_s = '0; i_cfg_count = '0; i_req_valid = '0; i_req_data = '0;
      @(posedge i_clk);
      #1;
      doReset(2);
      idleCycles(1);

      $display("[TB] start before any load");
      applyStimulus('0, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 0, 1'b0, '0);
      idleCycles(2);

      $display("[TB] single result");
      runLayer(1, 16'd2, 16'd3, MODE_SINGLE, 0, 1'b0, 32'h0001_0000);

      $display("[TB] round-robin fairness");
      doReset(1);
      runLayer(8, 16'($urandom), 16'($urandom), MODE_ALL, 0, 1'b0, '0);

      $display("[TB] backpressure and load during run");
      runLayer(10, 16'($urandom), 16'($urandom), MODE_STALL, 4, 1'b0, '0);

      $display("[TB] overflow");
      runLayer(1, 16'hFFFF, 16'hFFFF, MODE_SINGLE, 0, 1'b0, 32'hFFFF_FFFF);

      $display("[TB] empty layer");
      runLayer(0, 16'd5, 16'd7, MODE_ALL, 0, 1'b0, '0);

      $display("[TB] random layers");
      for (int l = 0; l < 15; l++) begin
         runLayer($urandom_range(0, 12), 16'($urandom), 16'($urandom), MODE_RANDOM, 0, (l % 3) == 0, '0);
         idleCycles($urandom_range(0, 2));
      end

      $display("[TB] reset mid-layer");
      applyStimulus('0, 1'b1, 1'b1, 1'b1, 16'd9, 16'd11, 6, 1'b0, '0);
      applyStimulus('1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 0, 1'b0, '0);
      applyStimulus('1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 0, 1'b0, '0);
      doReset(1);
      idleCycles(1);
      runLayer(5, 16'($urandom), 16'($urandom), MODE_RANDOM, 0, 1'b0, '0);
      idleCycles(2);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/dequant_scheduler.md
# dequant_scheduler

Sequencing and arbitration controller for the NPU dequantization stage. It shares one pipelined dequantization multiplier among several ReLU-output requesters using round-robin arbitration. It latches the per-layer image and weight scale factors and counts the results of a layer. It also drains the pipeline and signals layer completion. It sits between the PE-column ReLU outputs and the output writeback path.

## Interface
- N_REQ, 4, number of requester lanes (2..8)
- DATA_W, 32, ReLU input and dequantized output width
- SCALE_W, 16, used width of each scale factor (low bits of the 32-bit scale ports)
- CNT_W, 16, width of the layer result counter
- i_clk  in  1  single clock; all logic is on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_cfg_load  in  1  latch scales and count; honoured only in IDLE
- i_X_s  in  32  image scale factor; bits [SCALE_W-1:0] are used
- i_w_s  in  32  weight scale factor; bits [SCALE_W-1:0] are used
- i_cfg_count  in  CNT_W  number of results in the layer; 0 means an empty layer
- i_start  in  1  begin the layer; honoured only in IDLE after a load
- i_req_valid  in  N_REQ  per-lane ReLU data valid
- i_req_data  in  N_REQ*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
- o_req_ready  out  N_REQ  one-hot accept; a transfer occurs when valid and ready are both high
- o_valid  out  1  dequantized result valid
- o_data  out  DATA_W  dequantized result
- o_src_id  out  clog2(N_REQ)  lane that produced o_data
- i_ready  in  1  downstream accept
- o_busy  out  1  high in RUN or DRAIN
- o_done  out  1  one-cycle pulse at the end of a layer
- o_cfg_err  out  1  one-cycle pulse when i_cfg_load or i_start is ignored

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - i_cfg_load latches the scale and count registers and sets cfg_valid.
  - i_start with cfg_valid moves to RUN and clears the accepted counter.
  - i_start without cfg_valid pulses o_cfg_err.
  - If load and start arrive in the same cycle, the load applies first and the start is honoured.
- RUN:
  - One request is granted per cycle when the pipeline advances. The pipeline advances when stage 2 is empty or i_ready is high.
  - Round-robin: the search starts at the lane after the last granted lane; the pointer resets to lane 0.
  - The accepted counter increments on each transfer. When it reaches i_cfg_count, o_req_ready is forced low and the state moves to DRAIN.
  - i_cfg_load or i_start outside IDLE pulses o_cfg_err and is ignored.
- DRAIN: the state moves to IDLE and o_done pulses on the cycle after the last result leaves (o_valid && i_ready) and the pipeline is empty.
- Empty layer: start with count 0 goes RUN → DRAIN → IDLE without granting any request. o_done pulses 2 cycles after start.
- Arithmetic:
  - Stage 1 computes p1 = relu × X_s[15:0] at full width (48 bits).
  - Stage 2 computes p2 = p1 × w_s[15:0] (64 bits).
  - o_data = p2[DATA_W+15:16], i.e. a logical right shift by 16 followed by truncation.
  - All operands are unsigned.
- Backpressure: when o_valid && !i_ready, both stages hold, o_data and o_src_id stay stable, and no grant is issued.
- Reset mid-layer: in-flight results are discarded, the state returns to IDLE, and cfg_valid is cleared.

## Timing
- Reset values: o_req_ready=0, o_valid=0, o_data=0, o_src_id=0, o_busy=0, o_done=0, o_cfg_err=0. The state is IDLE and the round-robin pointer is 0.
- Latency: a transfer in cycle t gives o_valid in cycle t+2 when there is no backpressure.
- Throughput: 1 result per cycle.
- o_req_ready is combinational from the state, the pipeline-advance condition and the arbiter, and is at most one-hot. It depends on i_ready.
- o_busy is registered and rises the cycle after an accepted start.

## Configuration
- DEQUANT_SATURATE_EN defined: if p2[63:DATA_W+16] is non-zero, o_data = all ones (0xFFFFFFFF).
- DEQUANT_SATURATE_EN undefined: the result is silently truncated as described in Operation.

## Structure
- Package dequant_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - the DATA_W and SCALE_W defaults;
  - the shift constant DEQ_SHIFT=16.
- Sub-module rr_arbiter: N_REQ-wide round-robin arbiter.
  - Inputs: request, advance enable.
  - Outputs: one-hot grant, encoded index.
  - Holds the pointer register.
- The two multiply stages stay inline in dequant_scheduler.

## Test plan
- Single result: load X_s=2, w_s=3, count=1; start; lane 0 sends 0x0001_0000. Expect o_data=6, o_src_id=0 at t+2, then o_done one cycle after the handshake.
- Round-robin fairness: all 4 lanes hold valid, count=8. Grant order is 0,1,2,3,0,1,2,3, o_done pulses once, and no 9th grant occurs.
- Backpressure: hold i_ready low 3 cycles mid-stream. o_data stays stable, o_req_ready stays 0, and no result is lost or duplicated.
- Overflow: relu=0xFFFF_FFFF, X_s=w_s=0xFFFF.
  - Without the macro: o_data equals bits [47:16] of the exact product.
  - With DEQUANT_SATURATE_EN: o_data=0xFFFFFFFF.
- Protocol errors:
  - start before any load → o_cfg_err pulse, state stays IDLE.
  - load during RUN → o_cfg_err pulse, scales unchanged.
  - count=0 → o_done with no grants.
- Reset mid-layer: assert i_reset during RUN with 2 results in flight. All outputs return to reset values next cycle, and a new load/start runs cleanly.
